parking_occupancy: RTL and testbench
====================================

PARKING_OCCUPANCY -- requirements
Module: parking_occupancy

Interface
REQ-001 The module SHALL have parameter CAPACITY, default 20, meaning the number of parking spaces; legal range 1..99.
REQ-002 The module SHALL have parameter CW, default 7, meaning the width of the count and free outputs.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 S  input  1  add request from the entry/exit detector FSM; one car has entered.
REQ-006 R  input  1  subtract request from the detector FSM; one car has left.
REQ-007 clear  input  1  synchronous clear of the count and the error flags.
REQ-008 count  output  CW  cars currently inside, binary.
REQ-009 free  output  CW  free spaces, equal to CAPACITY - count.
REQ-010 bcd_tens, bcd_units  output  4 each  count as two BCD digits for the 7-segment display.
REQ-011 full, empty  output  1 each  count==CAPACITY and count==0 respectively.
REQ-012 entry_allow  output  1  barrier-open permission, equal to ~full.
REQ-013 err_ovf, err_unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-014 S and R SHALL be edge-detected against registered copies: inc = S & ~S_q and dec = R & ~R_q, so a request held high for N cycles counts once.
REQ-015 On an inc with count<CAPACITY, count SHALL increase by 1 at the same rising edge that first samples S high, and the new value SHALL be visible in the following cycle (1-cycle latency).
REQ-016 On a dec with count>0, count SHALL decrease by 1 with the same timing as REQ-015.
REQ-017 Simultaneous inc and dec in one cycle SHALL leave count unchanged and SHALL set no error flag.
REQ-018 An inc while count==CAPACITY SHALL hold count and set err_ovf; the count SHALL NOT wrap.
REQ-019 A dec while count==0 SHALL hold count and set err_unf; the count SHALL NOT wrap to all-ones.
REQ-020 err_ovf and err_unf SHALL stay set until clear or reset.
REQ-021 clear=1 SHALL force count=0, BCD=00, and both error flags to 0 at the next edge.
REQ-022 clear SHALL take priority over inc and dec in the same cycle.
REQ-023 The edge-detect registers SHALL still update during clear.
REQ-024 bcd_tens:bcd_units SHALL be held as registered BCD up/down digits updated in lockstep with count:
- units increment 9->0 SHALL carry into tens.
- units decrement 0->9 SHALL borrow from tens.
- The BCD value SHALL always equal count, with no conversion latency.
REQ-025 full, empty, free, and entry_allow SHALL be combinational from the count register and consistent with it in every cycle.
REQ-026 The states are the count values 0..CAPACITY; transitions are only +1, -1, hold, or clear-to-0.

Reset
REQ-027 While rst_n=0, the following SHALL be forced immediately, independent of clk:
- count=0, free=CAPACITY, bcd_tens=0, bcd_units=0
- empty=1, full=0, entry_allow=1
- err_ovf=0, err_unf=0
- S_q=0, R_q=0
REQ-028 A reset asserted mid-operation SHALL discard any pending inc or dec.
REQ-029 An S or R held high across reset release SHALL count once on the first edge after release, because S_q and R_q reset to 0.

Structure
REQ-030 A shared package SHALL hold the BCD digit width (4) and the maximum capacity constant (99).
REQ-031 One sub-module, bcd_updown_digit, SHALL be instantiated twice (units, tens).
- Ports: clk, rst_n, clr, up, down, carry_out, borrow_out, digit[3:0].
- Wrap behaviour: 9/0.
REQ-032 The parent SHALL gate the up and down inputs using the full and empty limits so that the BCD digits never move when the binary count holds.

Verification
REQ-033 Reset, then one S pulse of 3 cycles -> count=1, bcd=01, empty=0, one cycle after S first high; no further change.
REQ-034 With CAPACITY=20, 20 separated S pulses -> count=20, bcd=20, full=1, entry_allow=0; a 21st S pulse -> count stays 20, err_ovf=1.
REQ-035 From count=10, S and R rise in the same cycle -> count stays 10, no error flag.
REQ-036 From count=0, one R pulse -> count=0, err_unf=1; then clear=1 for one cycle -> err_unf=0.
REQ-037 From count=9, S pulse -> bcd=10; then R pulse -> bcd=09; free tracks as 11 then 11->... (CAPACITY=20): free=10 at count=10 and 11 at count=9.
REQ-038 rst_n asserted while count=15 and S high -> all outputs reach their reset values before the next clk edge; after release with S still high -> count=1.

Source files
------------

// File: rtl/parking_occupancy_pkg.sv
// Shared constants for the parking occupancy counter and its BCD display digits.
package parking_occupancy_pkg;

  // Width of one BCD display digit.
  localparam int BCD_W = 4;

  // Largest lot the two-digit display can show.
  localparam int MAX_CAPACITY = 99;

  // Largest value a single BCD digit can hold before it wraps.
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/parking_occupancy_bcd_updown_digit.sv
// One registered BCD up/down digit with 9->0 carry and 0->9 borrow.
// The digit cascades: the units digit drives the tens digit's up and down inputs.
module bcd_updown_digit
  import parking_occupancy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             up,
  input  logic             down,
  output logic             carry_out,
  output logic             borrow_out,
  output logic [BCD_W-1:0] digit
);

  logic [BCD_W-1:0] digit_nxt;

  // The carry and borrow are combinational so the next digit moves on the same edge.
  // Simultaneous up and down cancel out and produce neither.
  assign carry_out  = up & ~down & (digit == BCD_MAX);
  assign borrow_out = down & ~up & (digit == '0);

  // Next-digit value: wraps 9->0 going up and 0->9 going down.
  always_comb begin
    // NOTE: the default assignment first means every path assigns digit_nxt, so no latch is inferred.
    digit_nxt = digit;
    if (up && !down) begin
      digit_nxt = (digit == BCD_MAX) ? '0 : digit + BCD_W'(1);
    end else if (down && !up) begin
      digit_nxt = (digit == '0) ? BCD_MAX : digit - BCD_W'(1);
    end
  end

  // Digit register: cleared asynchronously by reset and synchronously by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else begin
      digit <= digit_nxt;
    end
  end

endmodule

// File: rtl/parking_occupancy.sv
// Parking lot occupancy counter. It counts the rising edges of the entry (S) and exit (R)
// requests, saturates at 0 and CAPACITY with sticky error flags, and keeps a
// lockstep two-digit BCD copy of the count for the display.
module parking_occupancy
  import parking_occupancy_pkg::*;
#(
  parameter int CAPACITY = 20,
  parameter int CW       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic             R,
  input  logic             clear,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_units,
  output logic             full,
  output logic             empty,
  output logic             entry_allow,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [CW-1:0] CAP_V = CW'(CAPACITY);

  logic s_q;
  logic r_q;
  logic inc;
  logic dec;
  logic do_inc;
  logic do_dec;
  logic ovf_evt;
  logic unf_evt;
  logic units_carry;
  logic units_borrow;
  logic tens_carry;
  logic tens_borrow;

  // A request held high counts only once: act on its rising edge.
  assign inc = S & ~s_q;
  assign dec = R & ~r_q;

  // Simultaneous entry and exit cancel out. Otherwise the move is either taken
  // or turned into a sticky error when the count is already at a limit.
  assign do_inc  = inc & ~dec & ~full;
  assign do_dec  = dec & ~inc & ~empty;
  assign ovf_evt = (inc & ~dec & full) | tens_carry;
  assign unf_evt = (dec & ~inc & empty) | tens_borrow;

  // Status outputs are decoded directly from the count register.
  assign full        = (count == CAP_V);
  assign empty       = (count == '0);
  assign entry_allow = ~full;
  assign free        = CAP_V - count;

  // Edge-detect copies, binary count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, as the hardware does.
      s_q <= S;
      r_q <= R;
      if (clear) begin
        count   <= '0;
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end else begin
        if (do_inc) begin
          count <= count + CW'(1);
        end else if (do_dec) begin
          count <= count - CW'(1);
        end
        if (ovf_evt) begin
          err_ovf <= 1'b1;
        end
        if (unf_evt) begin
          err_unf <= 1'b1;
        end
      end
    end
  end

  // Units digit moves exactly when the binary count moves.
  bcd_updown_digit u_units (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clear),
    .up         (do_inc),
    .down       (do_dec),
    .carry_out  (units_carry),
    .borrow_out (units_borrow),
    .digit      (bcd_units)
  );

  // The tens digit steps on a units wrap. Its own wrap would mean the count passed 99,
  // which the capacity limit rules out. That wrap is folded into the error flags as a guard.
  bcd_updown_digit u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clear),
    .up         (units_carry),
    .down       (units_borrow),
    .carry_out  (tens_carry),
    .borrow_out (tens_borrow),
    .digit      (bcd_tens)
  );

endmodule

// File: tb/tb_parking_occupancy.sv
// Self-checking bench for parking_occupancy (CAPACITY=20): a vector table for the
// basic single-step behaviour, plus hand-written sequences for fill, saturation,
// BCD carry/borrow, clear priority and mid-operation reset.
module tb_parking_occupancy;

  localparam int CAPACITY = 20;
  localparam int CW       = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          S;
  logic          R;
  logic          clear;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [3:0]    bcd_tens;
  logic [3:0]    bcd_units;
  logic          full;
  logic          empty;
  logic          entry_allow;
  logic          err_ovf;
  logic          err_unf;

  parking_occupancy #(.CAPACITY(CAPACITY), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .S           (S),
    .R           (R),
    .clear       (clear),
    .count       (count),
    .free        (free),
    .bcd_tens    (bcd_tens),
    .bcd_units   (bcd_units),
    .full        (full),
    .empty       (empty),
    .entry_allow (entry_allow),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic r;
    logic clr;
    int   cnt;
    logic ovf;
    logic unf;
  } vec_t;

  typedef struct {
    int   cnt;
    logic ovf;
    logic unf;
    int   step;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference model state.
  int   m_cnt;
  logic m_ovf;
  logic m_unf;
  logic m_sq;
  logic m_rq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int c, input logic ovf, input logic unf);
    check({tag, ".count"},       32'(count),       32'(c));
    check({tag, ".free"},        32'(free),        32'(CAPACITY - c));
    check({tag, ".bcd_tens"},    32'(bcd_tens),    32'(c / 10));
    check({tag, ".bcd_units"},   32'(bcd_units),   32'(c % 10));
    check({tag, ".full"},        32'(full),        32'(c == CAPACITY));
    check({tag, ".empty"},       32'(empty),       32'(c == 0));
    check({tag, ".entry_allow"}, 32'(entry_allow), 32'(c != CAPACITY));
    check({tag, ".err_ovf"},     32'(err_ovf),     32'(ovf));
    check({tag, ".err_unf"},     32'(err_unf),     32'(unf));
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_sq  = 1'b0;
    m_rq  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic clr);
    logic inc;
    logic dec;
    inc  = s & ~m_sq;
    dec  = r & ~m_rq;
    m_sq = s;
    m_rq = r;
    if (clr) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (inc && !dec) begin
      if (m_cnt == CAPACITY) m_ovf = 1'b1;
      else m_cnt++;
    end else if (dec && !inc) begin
      if (m_cnt == 0) m_unf = 1'b1;
      else m_cnt--;
    end
  endtask

  // Pop one expectation and compare it with the DUT after the edge has settled.
  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_outputs($sformatf("step%0d", e.step), e.cnt, e.ovf, e.unf);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, push the expectation, then check #1 after the rising edge.
  task automatic drive(input logic s, input logic r, input logic clr);
    exp_t e;
    @(negedge clk);
    S     = s;
    R     = r;
    clear = clr;
    model_step(s, r, clr);
    step_no++;
    e.cnt  = m_cnt;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.step = step_no;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  // Table-driven variant: the expectation comes from the table, and the model is kept in step.
  task automatic apply_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    S     = v.s;
    R     = v.r;
    clear = v.clr;
    model_step(v.s, v.r, v.clr);
    step_no++;
    e.cnt  = v.cnt;
    e.ovf  = v.ovf;
    e.unf  = v.unf;
    e.step = step_no;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  task automatic pulse_s();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_r();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[11];

  initial begin
    // Each row holds {S, R, clear, count after edge, err_ovf, err_unf}.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0}; // S rises: count 1 after one edge
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0}; // S held: no recount
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // exit: back to 0
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1}; // exit at empty: underflow, no wrap
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1}; // flag is sticky
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0}; // clear drops the flag
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // simultaneous at empty: hold, no flag
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    rst_n = 1'b0;
    S     = 1'b0;
    R     = 1'b0;
    clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset", 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

    // Fill to 10, crossing the 9->10 units carry.
    for (int i = 0; i < 10; i++) pulse_s();
    check("at10.free", 32'(free), 32'd10);
    pulse_r();                               // 10 -> 9: units borrow
    check("at9.bcd", 32'({bcd_tens, bcd_units}), 32'h09);
    check("at9.free", 32'(free), 32'd11);
    pulse_s();                               // back to 10
    drive(1'b1, 1'b1, 1'b0);                 // simultaneous entry and exit at 10
    drive(1'b0, 1'b0, 1'b0);

    // Fill to capacity, then one more entry.
    for (int i = 0; i < 10; i++) pulse_s();
    check("full.entry_allow", 32'(entry_allow), 32'd0);
    check("full.bcd", 32'({bcd_tens, bcd_units}), 32'h20);
    pulse_s();                               // 21st car: overflow, count holds
    check("ovf.count", 32'(count), 32'd20);
    check("ovf.flag", 32'(err_ovf), 32'd1);
    drive(1'b1, 1'b1, 1'b0);                 // simultaneous at full
    drive(1'b0, 1'b0, 1'b0);
    pulse_r();                               // 20 -> 19, ovf stays sticky
    pulse_s();

    // Clear wins over a coincident entry edge. S then stays high, so no new edge occurs.
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Mid-operation reset at count 15 with an entry pending.
    for (int i = 0; i < 15; i++) pulse_s();
    @(negedge clk);
    S = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset", 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("reset_held", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);                 // S held across release: counts once
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case the stimulus thread ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
